// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator. Buttons are synchronised and debounced, a prescaler
// paces pattern steps, and the step index maps to an LED image per mode.
module led_pattern_gen #(
  parameter int N_LEDS  = 8,
  parameter int N_BTN   = 7,
  parameter int CTR_LSB = 20,
  parameter int SPD_MAX = 3,
  parameter int DB_BITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn,
  output logic [N_LEDS-1:0] led,
  output logic [1:0]        mode,
  output logic              paused,
  output logic              tick
);
  // mode     | meaning
  // M_BOUNCE | single lit LED sweeps up then back down
  // M_ROTATE | single lit LED rotates upward
  // M_COUNT  | binary count of the step index
  // M_BAR    | bar graph growing from all-off to all-on
  typedef enum logic [1:0] {M_BOUNCE, M_ROTATE, M_COUNT, M_BAR} mode_e;

  localparam int SW = (SPD_MAX > 0) ? $clog2(SPD_MAX + 1) : 1;
  localparam logic [SW-1:0]     SPD_TOP     = SW'(SPD_MAX);
  localparam logic [N_LEDS-1:0] ONE         = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] N_V         = N_LEDS'(N_LEDS);
  localparam logic [N_LEDS-1:0] BOUNCE_FOLD = N_LEDS'(2 * N_LEDS - 2);
  localparam logic [N_LEDS-1:0] BOUNCE_LAST = N_LEDS'(2 * N_LEDS - 3);
  localparam logic [N_LEDS-1:0] ROTATE_LAST = N_LEDS'(N_LEDS - 1);

  logic [3:0]         sync1_q, sync2_q, db_lvl_q, db_dly_q, press;
  logic [DB_BITS-1:0] db_cnt_q [4];
  logic [CTR_LSB-1:0] pre_q, pre_d, pre_term;
  logic [SW-1:0]      spd_q, spd_d;
  logic [N_LEDS-1:0]  pos_q, pos_d, pos_last, led_q, led_d, bidx;
  mode_e              mode_q, mode_d;
  logic               paused_q, paused_d, step, unused_btn;

  // Only btn[3:0] are wired to functions; the rest are intentionally ignored.
  assign unused_btn = ^btn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_lvl_q <= '0;
      db_dly_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q  <= btn[3:0];
      sync2_q  <= sync1_q;
      db_dly_q <= db_lvl_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_lvl_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (&db_cnt_q[i]) begin
          db_cnt_q[i] <= '0;
          db_lvl_q[i] <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_BITS'(1);
        end
      end
    end
  end

  assign press = db_lvl_q & ~db_dly_q;

  always_comb begin
    pre_term = {CTR_LSB{1'b1}} >> spd_q;
    // A mode press outranks a step landing in the same cycle.
    step     = (pre_q == pre_term) && !paused_q && !press[0];

    spd_d = spd_q;
    if (press[1] && !press[2] && spd_q != SPD_TOP)   spd_d = spd_q + SW'(1);
    else if (press[2] && !press[1] && spd_q != '0)   spd_d = spd_q - SW'(1);

    if (press[0] || (spd_d != spd_q) || (pre_q == pre_term)) pre_d = '0;
    else                                                   pre_d = pre_q + CTR_LSB'(1);

    mode_d   = press[0] ? mode_e'(mode_q + 2'd1) : mode_q;
    paused_d = paused_q ^ press[3];

    case (mode_q)
      M_BOUNCE: pos_last = BOUNCE_LAST;
      M_ROTATE: pos_last = ROTATE_LAST;
      M_COUNT:  pos_last = '1;
      default:  pos_last = N_V;
    endcase

    pos_d = pos_q;
    if (press[0])  pos_d = '0;
    else if (step) pos_d = (pos_q == pos_last) ? '0 : pos_q + N_LEDS'(1);

    bidx = (pos_q < N_V) ? pos_q : BOUNCE_FOLD - pos_q;
    case (mode_q)
      M_BOUNCE: led_d = ONE << bidx;
      M_ROTATE: led_d = ONE << pos_q;
      M_COUNT:  led_d = pos_q;
      default:  led_d = ~({N_LEDS{1'b1}} << pos_q);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q    <= '0;
      spd_q    <= '0;
      pos_q    <= '0;
      mode_q   <= M_BOUNCE;
      paused_q <= 1'b0;
      led_q    <= '0;
    end else begin
      pre_q    <= pre_d;
      spd_q    <= spd_d;
      pos_q    <= pos_d;
      mode_q   <= mode_d;
      paused_q <= paused_d;
      led_q    <= led_d;
    end
  end

  assign led    = led_q;
  assign mode   = mode_q;
  assign paused = paused_q;
  assign tick   = step;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with small simulation parameters so that
// debounce and step periods are only a few clocks long.
module tb_led_pattern_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] btn = '0;
  logic [7:0] led;
  logic [1:0] mode;
  logic       paused;
  logic       tick;

  int tests = 0;
  int fails = 0;

  led_pattern_gen #(
    .N_LEDS(8), .N_BTN(7), .CTR_LSB(4), .SPD_MAX(3), .DB_BITS(2)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .led(led), .mode(mode), .paused(paused), .tick(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: observed no end of run, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [6:0] mask, input int hold);
    btn = mask;
    repeat (hold) @(negedge clk);
    btn = '0;
    repeat (8) @(negedge clk);
  endtask

  // Waits for the LED image to change (bounded), then compares it.
  task automatic next_led(input string tag, input logic [7:0] exp, output int cyc);
    logic [7:0] prev;
    prev = led;
    cyc  = 0;
    while (led === prev && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 32'(led), 32'(exp));
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 64);
  endtask

  task automatic measure_period(input string tag, input int exp);
    int n;
    wait_tick(n);
    wait_tick(n);
    check(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    logic [7:0] bounce_seq [14];
    logic [7:0] bar_seq [9];
    int c, n, ticks, changes;
    logic [7:0] held;

    bounce_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                   8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    bar_seq    = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};

    // Test 1: reset values, first step timing, bounce sequence
    repeat (2) @(negedge clk);
    check("rst_led", 32'(led), 32'h0);
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_paused", 32'(paused), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("t1_led_after_release", 32'(led), 32'h01);
    next_led("t1_first_step", 8'h02, c);
    check("t1_first_step_cycles", 32'(c), 32'd16);
    for (int k = 2; k <= 15; k++)
      next_led($sformatf("t1_bounce_%0d", k), bounce_seq[k % 14], c);
    wait_tick(n);
    @(negedge clk);
    check("t1_tick_width", 32'(tick), 32'h0);
    measure_period("t1_period_spd0", 16);

    // Test 2: glitch rejected, clean presses cycle the mode
    press(7'h01, 3);
    check("t2_glitch_mode", 32'(mode), 32'h0);
    press(7'h01, 6);
    check("t2_mode1", 32'(mode), 32'h1);
    check("t2_mode1_led", 32'(led), 32'h01);
    for (int k = 1; k <= 8; k++)
      next_led($sformatf("t2_rotate_%0d", k), 8'h01 << (k % 8), c);

    // Test 3: count and bar patterns
    press(7'h01, 6);
    check("t3_mode2", 32'(mode), 32'h2);
    check("t3_mode2_led", 32'(led), 32'h00);
    for (int k = 1; k <= 256; k++)
      next_led($sformatf("t3_count_%0d", k), 8'(k), c);
    press(7'h01, 6);
    check("t3_mode3", 32'(mode), 32'h3);
    check("t3_mode3_led", 32'(led), 32'h00);
    for (int k = 1; k <= 9; k++)
      next_led($sformatf("t3_bar_%0d", k), bar_seq[k - 1], c);
    press(7'h01, 6);
    check("t3_mode_wrap", 32'(mode), 32'h0);
    check("t3_mode_wrap_led", 32'(led), 32'h01);

    // Test 4: speed up/down with saturation, simultaneous press ignored
    repeat (5) press(7'h02, 6);
    measure_period("t4_period_spd3", 2);
    repeat (5) press(7'h04, 6);
    measure_period("t4_period_spd0", 16);
    press(7'h02, 6);
    measure_period("t4_period_spd1", 8);
    press(7'h06, 6);
    measure_period("t4_period_both", 8);
    press(7'h04, 6);
    measure_period("t4_period_back0", 16);

    // Test 5: pause, mode change while paused, resume
    n = 0;
    while (led === 8'h08 && n < 100) begin @(negedge clk); n++; end
    while (led !== 8'h08 && n < 400) begin @(negedge clk); n++; end
    check("t5_reach_08", 32'(led), 32'h08);
    press(7'h08, 6);
    check("t5_paused", 32'(paused), 32'h1);
    held = led;
    ticks = 0;
    changes = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tick) ticks++;
      if (led !== held) changes++;
    end
    check("t5_ticks_while_paused", 32'(ticks), 32'h0);
    check("t5_led_held", 32'(led), 32'h08);
    check("t5_led_changes", 32'(changes), 32'h0);
    press(7'h01, 6);
    check("t5_mode_paused", 32'(mode), 32'h1);
    check("t5_led_pos0", 32'(led), 32'h01);
    check("t5_still_paused", 32'(paused), 32'h1);
    changes = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (led !== 8'h01) changes++;
    end
    check("t5_pos0_held", 32'(changes), 32'h0);
    btn = 7'h08;
    n = 0;
    while (paused && n < 20) begin @(negedge clk); n++; end
    check("t5_unpaused", 32'(paused), 32'h0);
    check("t5_resume_led", 32'(led), 32'h01);
    btn = '0;
    next_led("t5_resume_1", 8'h02, c);
    next_led("t5_resume_2", 8'h04, c);

    // Test 6: reset while in mode 2, speed 2, paused
    press(7'h01, 6);
    repeat (2) press(7'h02, 6);
    measure_period("t6_period_spd2", 4);
    repeat (20) @(negedge clk);
    press(7'h08, 6);
    check("t6_pre_paused", 32'(paused), 32'h1);
    check("t6_pre_mode", 32'(mode), 32'h2);
    rst = 1'b1;
    #1;
    check("t6_rst_led", 32'(led), 32'h0);
    check("t6_rst_mode", 32'(mode), 32'h0);
    check("t6_rst_paused", 32'(paused), 32'h0);
    check("t6_rst_tick", 32'(tick), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_led_after_release", 32'(led), 32'h01);
    next_led("t6_first_step", 8'h02, c);
    check("t6_first_step_cycles", 32'(c), 32'd16);
    next_led("t6_bounce_2", 8'h04, c);
    next_led("t6_bounce_3", 8'h08, c);
    measure_period("t6_period_spd0", 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
